code_sequencer: RTL and testbench
=================================

Name: code_sequencer

Overview:
- Parametrised successor to the single-port code store: program memory plus an integrated program counter and a valid/ready fetch stream.
- Host loads a program line by line. On `active`, the block streams code words in order to the execution core.
- Supports jumps, loop (wrap) mode, end-of-program detection and out-of-range write flagging.
- Sits between the host loader and the neuron execution controller.

Parameters:
- CODE_SIZE, 12, width of one code word.
- MAX_CODE_LINE, 100, memory depth in lines.
- INDEX_WIDTH, 32, width of all line-index ports.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- is_write  in  1  write strobe for one code line.
- write_line  in  INDEX_WIDTH  target line of the write.
- write_data  in  CODE_SIZE  code word to store.
- write_error  out  1  one-cycle pulse: write rejected.
- active  in  1  run request; level-sensitive.
- loop_mode  in  1  1 = wrap to line 0 at end of program; 0 = stop.
- jump  in  1  take jump_target on the current handshake.
- jump_target  in  INDEX_WIDTH  next line when jump=1.
- code  out  CODE_SIZE  current code word (registered).
- code_index  out  INDEX_WIDTH  line number of `code`.
- code_valid  out  1  `code` and `code_index` are valid.
- code_ready  in  1  consumer accepts the word.
- busy  out  1  state is FETCH.
- done  out  1  program finished; held until `active` drops.
- program_length  out  INDEX_WIDTH  highest written line + 1.

Behaviour:
- **Reset** (synchronous): state=IDLE. `code`=0, `code_index`=0, `code_valid`=0, `busy`=0, `done`=0, `write_error`=0, `program_length`=0. Memory contents are not cleared and are retained.
- **Memory:** MAX_CODE_LINE x CODE_SIZE array. Reads are asynchronous into the output registers, so there is no extra pipeline stage.
- **Writes:** accepted at the clock edge only when all of the following hold:
  - is_write=1
  - write_line < MAX_CODE_LINE
  - state is IDLE or DONE
- **Accepted write:** mem[write_line] <= write_data, and program_length <= max(program_length, write_line+1).
- **Rejected write:** is_write=1 with out-of-range line, or any write in FETCH. Memory and program_length are unchanged; write_error=1 for the following cycle only.
- **State IDLE:**
  - If active=1 and program_length>0: go to FETCH. At the same edge, code<=mem[0], code_index<=0, code_valid<=1.
  - First valid word appears one cycle after `active` is sampled high.
  - If active=1 and program_length=0: go to DONE.
- **State FETCH:** busy=1. code/code_index are held stable while code_valid=1 and code_ready=0.
- **Handshake** (code_valid & code_ready at the edge): nxt = jump ? jump_target : code_index+1.
  - If nxt < program_length: code<=mem[nxt], code_index<=nxt, code_valid stays 1. Back-to-back one word per cycle when ready is held high.
  - If nxt >= program_length (end, or out-of-range jump) and loop_mode=1: load line 0.
  - If nxt >= program_length and loop_mode=0: go to DONE, code_valid<=0.
- **Jump scope:** `jump` and `jump_target` are ignored unless a handshake occurs.
- **Abort:** active=0 in FETCH returns to IDLE at the next edge with code_valid<=0. If a handshake coincides, the consumer has taken that word, but no next word is loaded.
- **State DONE:** done=1, code_valid=0, busy=0. Stays in DONE while active=1; active=0 returns to IDLE (done<=0). Re-running requires active to drop and rise again.
- **Simultaneous write and active in IDLE:** the write is performed and the FETCH transition uses the pre-write program_length and memory. Line 0 is read before the write lands.
- **Index arithmetic:** code_index+1 is computed at INDEX_WIDTH+1 bits, so there is no wrap before the length compare.
- **Reset mid-FETCH:** immediate return to the reset values above. The program stays in memory but program_length=0, so the host must rewrite or re-declare the program.

Test Plan:
- **Linear run:** reset, write lines 0..4 with 0x101..0x105, loop_mode=0, ready=1, active=1.
  - Expect code_valid from cycle+1 with 0x101..0x105 and code_index 0..4 on consecutive cycles.
  - Then code_valid=0, done=1 while active=1; drop active -> done=0.
- **Backpressure:** same program, code_ready toggled 1,0,0,1.
  - Expect code/code_index frozen during ready=0, no word skipped or duplicated.
- **Jump and loop:** 5-line program, loop_mode=1.
  - Handshake at index 2 with jump=1, jump_target=4 -> next index 4.
  - Handshake at index 4 -> index 0.
  - jump_target=9 -> index 0.
- **Write rejection:**
  - write_line=100 -> write_error pulses one cycle, program_length unchanged.
  - Write during FETCH -> write_error pulses, memory word unchanged on later readback.
- **Abort and reset:**
  - active drops at index 2 -> next cycle code_valid=0, busy=0, state IDLE; re-run restarts at index 0.
  - reset asserted mid-run -> all outputs 0, program_length=0.
- **Empty program:** after reset, active=1 -> done=1 next cycle, code_valid never asserted.

Source files
------------

// File: rtl/code_sequencer.sv
// Program store with an integrated program counter: the host loads code lines,
// then the block streams them in order (with jumps and optional wrap) to a consumer.
module code_sequencer #(
  parameter int CODE_SIZE     = 12,
  parameter int MAX_CODE_LINE = 100,
  parameter int INDEX_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   is_write,
  input  logic [INDEX_WIDTH-1:0] write_line,
  input  logic [CODE_SIZE-1:0]   write_data,
  output logic                   write_error,
  input  logic                   active,
  input  logic                   loop_mode,
  input  logic                   jump,
  input  logic [INDEX_WIDTH-1:0] jump_target,
  output logic [CODE_SIZE-1:0]   code,
  output logic [INDEX_WIDTH-1:0] code_index,
  output logic                   code_valid,
  input  logic                   code_ready,
  output logic                   busy,
  output logic                   done,
  output logic [INDEX_WIDTH-1:0] program_length,
  output logic [1:0]             state_dbg
);

  localparam int ADDR_W = (MAX_CODE_LINE > 1) ? $clog2(MAX_CODE_LINE) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CODE_SIZE-1:0]   mem [MAX_CODE_LINE];
  logic [INDEX_WIDTH:0]   nxt_line;
  logic [INDEX_WIDTH:0]   max_line;
  logic [INDEX_WIDTH:0]   wr_end;
  logic                   handshake;
  logic                   nxt_in_range;
  logic                   wr_accept;
  logic                   load_word;
  logic [INDEX_WIDTH-1:0] rd_index;
  logic [ADDR_W-1:0]      rd_addr;

  // Stream handshake: a word transfers on any edge where code_valid and code_ready
  // are both high; while valid is high and ready low, code/code_index hold still.
  assign handshake = code_valid & code_ready;

  // One extra bit so code_index+1 never wraps before the length compare.
  assign nxt_line     = jump ? {1'b0, jump_target}
                             : {1'b0, code_index} + (INDEX_WIDTH+1)'(1);
  assign nxt_in_range = nxt_line < {1'b0, program_length};

  assign max_line  = (INDEX_WIDTH+1)'(MAX_CODE_LINE);
  assign wr_end    = {1'b0, write_line} + (INDEX_WIDTH+1)'(1);
  assign wr_accept = is_write && ({1'b0, write_line} < max_line) && (state != FETCH);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (active) state_nxt = (program_length != '0) ? FETCH : DONE;
      end
      FETCH: begin
        if (!active)                                    state_nxt = IDLE;
        else if (handshake && !nxt_in_range && !loop_mode) state_nxt = DONE;
      end
      DONE: begin
        if (!active) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == FETCH);
    done      = (state == DONE);
    state_dbg = state;
  end

  // Selects which line (if any) is loaded into the output registers this edge.
  always_comb begin
    load_word = 1'b0;
    rd_index  = '0;
    if (state == IDLE && active && program_length != '0) begin
      load_word = 1'b1;
    end else if (state == FETCH && active && handshake && (nxt_in_range || loop_mode)) begin
      load_word = 1'b1;
      rd_index  = nxt_in_range ? nxt_line[INDEX_WIDTH-1:0] : '0;
    end
  end

  assign rd_addr = rd_index[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      code           <= '0;
      code_index     <= '0;
      code_valid     <= 1'b0;
      write_error    <= 1'b0;
      program_length <= '0;
    end else begin
      write_error <= is_write && !wr_accept;
      if (wr_accept && (wr_end > {1'b0, program_length}))
        program_length <= wr_end[INDEX_WIDTH-1:0];
      if (load_word) begin
        code       <= mem[rd_addr];
        code_index <= rd_index;
        code_valid <= 1'b1;
      end else if (state == FETCH && (!active || handshake)) begin
        code_valid <= 1'b0;
      end
    end
  end

  // Memory is never cleared; a reset only forgets the program length.
  always_ff @(posedge clk) begin
    if (!reset && wr_accept)
      mem[write_line[ADDR_W-1:0]] <= write_data;
  end

endmodule

// File: tb/tb_code_sequencer.sv
// Bench for code_sequencer: directed scenarios plus randomized runs, every cycle
// compared against a line-level model of the program store and its fetch stream.
module tb_code_sequencer;
  localparam int CS = 12;
  localparam int ML = 100;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          reset, is_write, active, loop_mode, jump, code_ready;
  logic [IW-1:0] write_line, jump_target;
  logic [CS-1:0] write_data;
  logic          write_error, code_valid, busy, done;
  logic [CS-1:0] code;
  logic [IW-1:0] code_index, program_length;
  logic [1:0]    state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: phase 0 = idle, 1 = streaming, 2 = finished.
  logic [CS-1:0] m_mem [ML];
  longint        m_len, m_idx;
  int            m_st;
  logic          m_valid, m_werr;
  logic [CS-1:0] m_code;

  code_sequencer #(.CODE_SIZE(CS), .MAX_CODE_LINE(ML), .INDEX_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .is_write(is_write), .write_line(write_line),
    .write_data(write_data), .write_error(write_error), .active(active),
    .loop_mode(loop_mode), .jump(jump), .jump_target(jump_target),
    .code(code), .code_index(code_index), .code_valid(code_valid),
    .code_ready(code_ready), .busy(busy), .done(done),
    .program_length(program_length), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [CS-1:0] old0;
    longint        n, pre_len;
    int            pre_st;
    if (reset) begin
      m_st = 0; m_idx = 0; m_valid = 1'b0; m_werr = 1'b0; m_len = 0; m_code = '0;
      return;
    end
    old0    = m_mem[0];
    pre_st  = m_st;
    pre_len = m_len;
    if (is_write) begin
      if (longint'(write_line) < ML && pre_st != 1) begin
        m_mem[write_line] = write_data;
        if (longint'(write_line) + 1 > m_len) m_len = longint'(write_line) + 1;
        m_werr = 1'b0;
      end else begin
        m_werr = 1'b1;
      end
    end else begin
      m_werr = 1'b0;
    end
    case (pre_st)
      0: if (active) begin
        if (pre_len > 0) begin
          m_st = 1; m_idx = 0; m_valid = 1'b1; m_code = old0;
        end else begin
          m_st = 2;
        end
      end
      1: if (!active) begin
        m_st = 0; m_valid = 1'b0;
      end else if (code_ready) begin
        n = jump ? longint'(jump_target) : m_idx + 1;
        if (n < m_len)      m_idx = n;
        else if (loop_mode) m_idx = 0;
        else begin m_st = 2; m_valid = 1'b0; end
        if (m_valid) m_code = m_mem[m_idx];
      end
      default: if (!active) m_st = 0;
    endcase
  endtask

  task automatic compare_all();
    check("code_valid", code_valid, m_valid);
    check("busy", busy, m_st == 1);
    check("done", done, m_st == 2);
    check("write_error", write_error, m_werr);
    check("program_length", program_length, m_len);
    check("state", state_dbg, m_st);
    if (m_valid) begin
      check("code_index", code_index, m_idx);
      check("code", code, m_code);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic wr(input int line, input logic [CS-1:0] data);
    is_write = 1'b1; write_line = line; write_data = data;
    tick();
    is_write = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; active = 1'b0; is_write = 1'b0; jump = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; is_write = 1'b0; write_line = '0; write_data = '0; active = 1'b0;
    loop_mode = 1'b0; jump = 1'b0; jump_target = '0; code_ready = 1'b1;
    m_st = 0; m_len = 0; m_idx = 0; m_valid = 1'b0; m_werr = 1'b0; m_code = '0;
    for (int i = 0; i < ML; i++) m_mem[i] = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_code", code, 0);
    check("rst_plen", program_length, 0);

    // Empty program finishes immediately.
    active = 1'b1; tick();
    check("empty_done", done, 1);
    tick();
    active = 1'b0; tick();

    // Linear run.
    for (int i = 0; i < 5; i++) wr(i, CS'(12'h101 + i));
    check("lin_plen", program_length, 5);
    loop_mode = 1'b0; code_ready = 1'b1; active = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("lin_code", code, 12'h101 + i);
      check("lin_index", code_index, i);
    end
    tick();
    check("lin_end_valid", code_valid, 0);
    check("lin_end_done", done, 1);
    tick();
    active = 1'b0; tick();
    check("lin_done_drop", done, 0);

    // Backpressure with ready pattern 1,0,0,1.
    active = 1'b1; tick();
    for (int i = 0; i < 16; i++) begin
      code_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    code_ready = 1'b1;
    active = 1'b0; tick();

    // Jump and loop.
    loop_mode = 1'b1; active = 1'b1;
    tick(); tick(); tick();
    check("jl_at2", code_index, 2);
    jump = 1'b1; jump_target = 4; tick();
    check("jl_jump4", code_index, 4);
    jump = 1'b0; tick();
    check("jl_wrap0", code_index, 0);
    tick();
    jump = 1'b1; jump_target = 9; tick();
    check("jl_oor_jump", code_index, 0);
    jump = 1'b0;

    // Write rejection: during FETCH, then out of range.
    is_write = 1'b1; write_line = 1; write_data = 12'habc; tick();
    is_write = 1'b0;
    check("wr_fetch_err", write_error, 1);
    tick();
    check("wr_err_pulse", write_error, 0);
    active = 1'b0; tick();
    wr(100, 12'h777);
    check("wr_oor_err", write_error, 1);
    check("wr_oor_plen", program_length, 5);
    tick();
    loop_mode = 1'b0; active = 1'b1;
    tick(); tick();
    check("readback_line1", code, 12'h102);
    for (int i = 0; i < 5; i++) tick();
    active = 1'b0; tick();

    // Abort at index 2, then re-run.
    active = 1'b1; tick(); tick(); tick();
    active = 1'b0; tick();
    check("abort_valid", code_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_state", state_dbg, 0);
    active = 1'b1; tick();
    check("rerun_index", code_index, 0);
    tick();

    // Reset mid-run.
    reset = 1'b1; tick();
    check("midrst_valid", code_valid, 0);
    check("midrst_plen", program_length, 0);
    reset = 1'b0; active = 1'b0; tick();

    // Write coinciding with start: old length and old line 0 are used.
    active = 1'b1; is_write = 1'b1; write_line = 0; write_data = 12'h0aa; tick();
    is_write = 1'b0;
    check("simul_empty_done", done, 1);
    active = 1'b0; tick();
    wr(1, 12'h0bb);
    active = 1'b1; is_write = 1'b1; write_line = 0; write_data = 12'h0cc; tick();
    is_write = 1'b0;
    check("simul_old_word", code, 12'h0aa);
    for (int i = 0; i < 3; i++) tick();
    active = 1'b0; tick();

    // Randomized programs and traffic.
    for (int p = 0; p < 20; p++) begin
      int n;
      do_reset();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) wr(i, CS'($urandom));
      loop_mode = $urandom_range(0, 1);
      active = 1'b1;
      for (int c = 0; c < 40; c++) begin
        code_ready  = ($urandom_range(0, 3) != 0);
        jump        = ($urandom_range(0, 4) == 0);
        jump_target = $urandom_range(0, n + 2);
        is_write    = ($urandom_range(0, 9) == 0);
        write_line  = $urandom_range(0, 1) ? $urandom_range(0, n - 1) : $urandom_range(100, 200);
        write_data  = CS'($urandom);
        if ($urandom_range(0, 15) == 0) active = !active;
        tick();
      end
      is_write = 1'b0; jump = 1'b0; active = 1'b0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
